// File: rtl/decodificador_display.sv
// MM:SS 4-digit multiplexed 7-seg driver; blink phase built only with DISPLAY_BLINK_EN.
// Outputs registered 1 cycle after idx/data change; no backpressure (load strobe always accepted).
module decodificador_display #(
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_SCANS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        carregar,
  input  logic [15:0] digitos,
  input  logic        piscar,
  output logic [6:0]  segmentos,
  output logic        ponto,
  output logic [3:0]  anodo,
  output logic        erro
);

  logic [15:0] dados;
  logic [15:0] presc;
  logic [1:0]  idx;
  logic        tick;
  logic        visivel;
  logic [3:0]  nib;
  logic [6:0]  seg_dec;
  logic [6:0]  seg_nxt;
  logic [3:0]  an_nxt;
  logic        pt_nxt;

  function automatic logic palavra_invalida(input logic [15:0] w);
    return (w[15:12] > 4'd9) || (w[11:8] > 4'd9) || (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
  endfunction

  assign tick = (presc == 16'(SCAN_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dados <= 16'h0000;
      erro  <= 1'b0;
    end else if (carregar) begin
      dados <= digitos;
      erro  <= palavra_invalida(digitos);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= 16'd0;
      idx   <= 2'd0;
    end else if (tick) begin
      presc <= 16'd0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

`ifdef DISPLAY_BLINK_EN
  logic [7:0] cnt_pisca;
  logic       fase;
  logic       fim_varredura;

  assign fim_varredura = tick && (idx == 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_pisca <= 8'd0;
      fase      <= 1'b1;
    end else if (!piscar) begin
      cnt_pisca <= 8'd0;
      fase      <= 1'b1;
    end else if (fim_varredura) begin
      if (cnt_pisca == 8'(BLINK_SCANS - 1)) begin
        cnt_pisca <= 8'd0;
        fase      <= ~fase;
      end else begin
        cnt_pisca <= cnt_pisca + 8'd1;
      end
    end
  end

  // Gating with the live piscar lets the display come back on the very edge piscar drops.
  assign visivel = fase | ~piscar;
`else
  localparam int unused_blink_scans = BLINK_SCANS;
  logic unused_piscar;
  assign unused_piscar = piscar;
  assign visivel       = 1'b1;
`endif

  always_comb begin
    nib = dados[{idx, 2'b00} +: 4];
    case (nib)
      4'd0:    seg_dec = 7'h7E;
      4'd1:    seg_dec = 7'h30;
      4'd2:    seg_dec = 7'h6D;
      4'd3:    seg_dec = 7'h79;
      4'd4:    seg_dec = 7'h33;
      4'd5:    seg_dec = 7'h5B;
      4'd6:    seg_dec = 7'h5F;
      4'd7:    seg_dec = 7'h70;
      4'd8:    seg_dec = 7'h7F;
      4'd9:    seg_dec = 7'h7B;
      default: seg_dec = 7'h01;
    endcase
    // Only the tens-of-minutes digit is blanked when zero.
    seg_nxt = ((idx == 2'd3) && (nib == 4'd0)) ? 7'h00 : seg_dec;
    an_nxt  = 4'b0001 << idx;
    pt_nxt  = (idx == 2'd2);
    if (!visivel) begin
      seg_nxt = 7'h00;
      an_nxt  = 4'b0000;
      pt_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      segmentos <= 7'h00;
      anodo     <= 4'b0000;
      ponto     <= 1'b0;
    end else begin
      segmentos <= seg_nxt;
      anodo     <= an_nxt;
      ponto     <= pt_nxt;
    end
  end

endmodule

// File: tb/tb_decodificador_display.sv
// Bench for decodificador_display: spec-table vectors, directed corner sequences and
// random traffic checked every cycle against a cycle-count based display model.
module tb_decodificador_display;
  localparam int SCAN_DIV    = 4;
  localparam int BLINK_SCANS = 2;
  localparam int SCAN_LEN    = 4 * SCAN_DIV;
`ifdef DISPLAY_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        carregar;
  logic [15:0] digitos;
  logic        piscar;
  logic [6:0]  segmentos;
  logic        ponto;
  logic [3:0]  anodo;
  logic        erro;

  decodificador_display #(.SCAN_DIV(SCAN_DIV), .BLINK_SCANS(BLINK_SCANS)) dut (
    .clock(clock), .reset_n(reset_n), .carregar(carregar), .digitos(digitos),
    .piscar(piscar), .segmentos(segmentos), .ponto(ponto), .anodo(anodo), .erro(erro)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edges since reset release, latched word, wraps seen while piscar high.
  int          k;
  logic [15:0] mdata;
  logic        merro;
  int          wraps;
  int          e_idx;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_pt;

  typedef struct packed {
    logic [15:0]     w;
    logic [3:0][6:0] s;
    logic            err;
  } vec_t;
  vec_t vt[7];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    return (d > 4'd9) ? 7'h01 : tab[d];
  endfunction

  function automatic logic has_bad(input logic [15:0] w);
    logic r = 1'b0;
    for (int i = 0; i < 4; i++) if (((w >> (4 * i)) & 16'hF) > 16'd9) r = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; mdata = 16'h0000; merro = 1'b0; wraps = 0;
  endtask

  // One clock edge: predict from pre-edge state and inputs, advance model, compare at negedge.
  task automatic cycle();
    logic [3:0] nb;
    logic       off;
    @(posedge clock);
    e_idx = (k / SCAN_DIV) % 4;
    nb    = mdata[e_idx*4 +: 4];
    off   = BLINK_ON && piscar && ((wraps / BLINK_SCANS) % 2 == 1);
    e_seg = off ? 7'h00 : ((e_idx == 3 && nb == 4'd0) ? 7'h00 : seg_of(nb));
    e_an  = off ? 4'b0000 : 4'(1 << e_idx);
    e_pt  = !off && (e_idx == 2);
    if (carregar) begin
      mdata = digitos;
      merro = has_bad(digitos);
    end
    if (!piscar) wraps = 0;
    else if ((k + 1) % SCAN_LEN == 0) wraps++;
    k++;
    @(negedge clock);
    check("anodo", 32'(anodo), 32'(e_an));
    check("segmentos", 32'(segmentos), 32'(e_seg));
    check("ponto", 32'(ponto), 32'(e_pt));
    check("erro", 32'(erro), 32'(merro));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_anodo"}, 32'(anodo), 32'h0);
    check({name, "_seg"}, 32'(segmentos), 32'h0);
    check({name, "_ponto"}, 32'(ponto), 32'h0);
    check({name, "_erro"}, 32'(erro), 32'h0);
  endtask

  initial begin
    int          z;
    bit          found;
    logic [15:0] w;

    vt[0] = '{16'h0930, {7'h00, 7'h7B, 7'h79, 7'h7E}, 1'b0};
    vt[1] = '{16'h1A25, {7'h30, 7'h01, 7'h6D, 7'h5B}, 1'b1};
    vt[2] = '{16'h1225, {7'h30, 7'h6D, 7'h6D, 7'h5B}, 1'b0};
    vt[3] = '{16'h5959, {7'h5B, 7'h7B, 7'h5B, 7'h7B}, 1'b0};
    vt[4] = '{16'h0000, {7'h00, 7'h7E, 7'h7E, 7'h7E}, 1'b0};
    vt[5] = '{16'h8764, {7'h7F, 7'h70, 7'h5F, 7'h33}, 1'b0};
    vt[6] = '{16'hF9FB, {7'h01, 7'h7B, 7'h01, 7'h01}, 1'b1};

    reset_n = 1'b0; carregar = 1'b0; piscar = 1'b0; digitos = 16'h0000;
    model_reset();
    repeat (3) @(negedge clock);
    check_zero_outputs("in_reset");
    reset_n = 1'b1;

    // First edge shows digit 0 = 0, then rotation every SCAN_DIV cycles.
    cycle();
    check("first_anodo", 32'(anodo), 32'h1);
    check("first_seg", 32'(segmentos), 32'h7E);
    run(2 * SCAN_LEN);

    for (int i = 0; i < 7; i++) begin
      carregar = 1'b1; digitos = vt[i].w;
      cycle();
      carregar = 1'b0;
      check("tbl_erro", 32'(erro), 32'(vt[i].err));
      for (int c = 0; c < SCAN_LEN; c++) begin
        cycle();
        check("tbl_seg", 32'(segmentos), 32'(vt[i].s[e_idx]));
      end
    end

    // Load on a scan tick edge: next digit must show the new word.
    while (k % SCAN_DIV != SCAN_DIV - 1) cycle();
    carregar = 1'b1; digitos = 16'h5959;
    cycle();
    carregar = 1'b0;
    cycle();
    check("tick_load_seg", 32'(segmentos), 32'(seg_of(4'(16'h5959 >> (4 * e_idx)))));

    // carregar held high: last value wins.
    carregar = 1'b1;
    for (int i = 0; i < 10; i++) begin
      digitos = 16'($urandom);
      cycle();
    end
    carregar = 1'b0;
    run(SCAN_LEN);

    if (BLINK_ON) begin
      carregar = 1'b1; digitos = 16'h0105; cycle(); carregar = 1'b0;
      piscar = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
        cycle();
        if (anodo == 4'b0000) found = 1'b1;
      end
      check("blink_off_seen", 32'(found), 32'h1);
      z = 1;
      forever begin
        cycle();
        if (anodo != 4'b0000 || z >= 200) break;
        z++;
      end
      check("blink_off_len", 32'(z), 32'(SCAN_LEN * BLINK_SCANS));
      check("blink_resume", 32'(anodo), 32'h1);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
        cycle();
        if (anodo == 4'b0000) found = 1'b1;
      end
      check("blink_off_again", 32'(found), 32'h1);
      run(3);
      piscar = 1'b0;
      cycle();
      check("blink_drop_on", 32'(anodo != 4'b0000), 32'h1);
      run(SCAN_LEN);
    end else begin
      piscar = 1'b1;
      z = 0;
      for (int i = 0; i < 10 * SCAN_LEN; i++) begin
        cycle();
        if (anodo == 4'b0000) z++;
      end
      check("noblink_zero_cycles", 32'(z), 32'h0);
      piscar = 1'b0;
    end

    // Random traffic; occasional invalid nibbles and long piscar runs.
    for (int i = 0; i < 2000; i++) begin
      carregar = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) w = 16'($urandom);
      else w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 3) == 0) w[15:12] = 4'd0;
      digitos = w;
      if ($urandom_range(0, 149) == 0) piscar = ~piscar;
      cycle();
    end
    carregar = 1'b0; piscar = 1'b0;

    // Asynchronous reset mid-digit, then data must read back as 0000.
    carregar = 1'b1; digitos = 16'h5959; cycle(); carregar = 1'b0;
    run(SCAN_DIV + 1);
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    run(SCAN_LEN);
    check("post_reset_seg", 32'(segmentos), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
